// File: rtl/shared_ram_pkg.sv
// Shared definitions for the two-port byte-enabled RAM arbiter.
//   PRIO_A / PRIO_B : fairness FSM states (which port wins the next conflict)
//   WE_MAX          : widest byte-enable vector accepted by any_we()
//   any_we()        : reduction-OR of a byte-enable vector (nonzero means write)
package shared_ram_pkg;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    localparam int WE_MAX = 16;

    // Callers zero-extend their enables to WE_MAX bits.
    function automatic logic any_we(input logic [WE_MAX-1:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/shared_ram_arb_if.sv
// Request/response bundle for one requestor port of shared_ram_arb.
//   valid/ready : request handshake, accepted when both are high
//   addr        : word address
//   wdata/we    : write data and byte enables (we == 0 means read)
//   rdata/rvalid: read return data and its one-cycle valid strobe
interface shared_ram_arb_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int NBYTES     = 4
);
    logic                    valid;
    logic                    ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [8*NBYTES-1:0]     wdata;
    logic [NBYTES-1:0]       we;
    logic [8*NBYTES-1:0]     rdata;
    logic                    rvalid;

    modport master (output valid, addr, wdata, we, input ready, rdata, rvalid);
    modport slave  (input valid, addr, wdata, we, output ready, rdata, rvalid);
endinterface

// File: rtl/true_dual_port_ram_single_clock.sv
// Single-clock true dual-port RAM, one byte wide per instance.
//   data_x/addr_x/we_x : write data, address and write enable of port x
//   q_x                : registered read data of port x (written data on a write)
// Contents are deliberately not reset.
module true_dual_port_ram_single_clock #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b
);
    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    // Both ports write and read the storage array on the rising edge.
    always_ff @(posedge clk) begin
        if (we_a) begin
            ram[addr_a] <= data_a;
            q_a         <= data_a;
        end else begin
            q_a <= ram[addr_a];
        end
        if (we_b) begin
            ram[addr_b] <= data_b;
            q_b         <= data_b;
        end else begin
            q_b <= ram[addr_b];
        end
    end
endmodule

// File: rtl/shared_ram_arb.sv
// Byte-enabled shared RAM with two arbitrated requestor ports.
//   clk          : rising-edge clock
//   resetn       : asynchronous active-low reset
//   port_a/b     : request/response ports (slave side of shared_ram_arb_if)
//   conflict_cnt : saturating count of cycles in which one port was stalled
// A same-address access involving a write is a conflict; the fairness bit
// decides the winner and flips after every conflict so the ports alternate.
module shared_ram_arb
    import shared_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int NBYTES     = 4,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    shared_ram_arb_if.slave      port_a,
    shared_ram_arb_if.slave      port_b,
    output logic [CNT_WIDTH-1:0] conflict_cnt
);
    localparam int DW = 8 * NBYTES;

    logic                 conflict_s;
    logic                 a_ready_s, b_ready_s;
    logic                 a_rd_s, b_rd_s;
    logic [NBYTES-1:0]    a_lane_we_s, b_lane_we_s;
    logic [DW-1:0]        a_q_s, b_q_s;
    logic                 prio_d, prio_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 a_rv1_d, a_rv1_q, b_rv1_d, b_rv1_q;

    // Conflict detection, ready generation, fairness and counter next-state.
    always_comb begin
        conflict_s = port_a.valid & port_b.valid & (port_a.addr == port_b.addr)
                   & (any_we(WE_MAX'(port_a.we)) | any_we(WE_MAX'(port_b.we)));
        // Nothing is accepted while in reset, which keeps the RAM untouched.
        if (!resetn) begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end else if (conflict_s) begin
            a_ready_s = (prio_q == PRIO_A);
            b_ready_s = (prio_q == PRIO_B);
        end else begin
            a_ready_s = 1'b1;
            b_ready_s = 1'b1;
        end
        a_lane_we_s = port_a.we & {NBYTES{port_a.valid & a_ready_s}};
        b_lane_we_s = port_b.we & {NBYTES{port_b.valid & b_ready_s}};
        a_rd_s      = port_a.valid & a_ready_s & ~any_we(WE_MAX'(port_a.we));
        b_rd_s      = port_b.valid & b_ready_s & ~any_we(WE_MAX'(port_b.we));
        a_rv1_d     = a_rd_s;
        b_rv1_d     = b_rd_s;
        // A conflict always stalls the non-priority port, so priority hands over.
        case (prio_q)
            PRIO_A:  prio_d = conflict_s ? PRIO_B : PRIO_A;
            PRIO_B:  prio_d = conflict_s ? PRIO_A : PRIO_B;
            default: prio_d = PRIO_A;
        endcase
        if (conflict_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Arbitration state, conflict counter and first read-valid stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q  <= PRIO_A;
            cnt_q   <= {CNT_WIDTH{1'b0}};
            a_rv1_q <= 1'b0;
            b_rv1_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            a_rv1_q <= a_rv1_d;
            b_rv1_q <= b_rv1_d;
        end
    end

    assign port_a.ready = a_ready_s;
    assign port_b.ready = b_ready_s;
    assign conflict_cnt = cnt_q;

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        true_dual_port_ram_single_clock #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk    (clk),
            .data_a (port_a.wdata[8*i +: 8]),
            .data_b (port_b.wdata[8*i +: 8]),
            .addr_a (port_a.addr),
            .addr_b (port_b.addr),
            .we_a   (a_lane_we_s[i]),
            .we_b   (b_lane_we_s[i]),
            .q_a    (a_q_s[8*i +: 8]),
            .q_b    (b_q_s[8*i +: 8])
        );
    end

    if (OUT_REG == 0) begin : g_out_direct
        // The RAM output changes every cycle, so a hold register keeps the
        // last returned word visible while rvalid is low.
        logic [DW-1:0] a_hold_d, a_hold_q, b_hold_d, b_hold_q;

        // Capture RAM data on each returning read.
        always_comb begin
            a_hold_d = a_rv1_q ? a_q_s : a_hold_q;
            b_hold_d = b_rv1_q ? b_q_s : b_hold_q;
        end

        // Hold registers for the last returned word.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                a_hold_q <= {DW{1'b0}};
                b_hold_q <= {DW{1'b0}};
            end else begin
                a_hold_q <= a_hold_d;
                b_hold_q <= b_hold_d;
            end
        end

        assign port_a.rdata  = a_hold_d;
        assign port_b.rdata  = b_hold_d;
        assign port_a.rvalid = a_rv1_q;
        assign port_b.rvalid = b_rv1_q;
    end else begin : g_out_reg
        logic          a_rv2_d, a_rv2_q, b_rv2_d, b_rv2_q;
        logic [DW-1:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;

        // Second pipeline stage: load output data only on a returning read.
        always_comb begin
            a_rv2_d   = a_rv1_q;
            b_rv2_d   = b_rv1_q;
            a_rdata_d = a_rv1_q ? a_q_s : a_rdata_q;
            b_rdata_d = b_rv1_q ? b_q_s : b_rdata_q;
        end

        // Output registers for data and valid.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                a_rv2_q   <= 1'b0;
                b_rv2_q   <= 1'b0;
                a_rdata_q <= {DW{1'b0}};
                b_rdata_q <= {DW{1'b0}};
            end else begin
                a_rv2_q   <= a_rv2_d;
                b_rv2_q   <= b_rv2_d;
                a_rdata_q <= a_rdata_d;
                b_rdata_q <= b_rdata_d;
            end
        end

        assign port_a.rdata  = a_rdata_q;
        assign port_b.rdata  = b_rdata_q;
        assign port_a.rvalid = a_rv2_q;
        assign port_b.rvalid = b_rv2_q;
    end
endmodule

// File: tb/tb_shared_ram_arb.sv
// Bench for shared_ram_arb: two instances (OUT_REG=0/CNT_WIDTH=16 and
// OUT_REG=1/CNT_WIDTH=3) share one stimulus stream and are compared against
// a word-array memory model with a queue of expected read returns.
module tb_shared_ram_arb;
    localparam int AW = 6;
    localparam int NB = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [NB-1:0] a_we, b_we;
    logic [15:0]   cnt0;
    logic [2:0]    cnt1;

    shared_ram_arb_if #(.ADDR_WIDTH(AW), .NBYTES(NB)) if0_a ();
    shared_ram_arb_if #(.ADDR_WIDTH(AW), .NBYTES(NB)) if0_b ();
    shared_ram_arb_if #(.ADDR_WIDTH(AW), .NBYTES(NB)) if1_a ();
    shared_ram_arb_if #(.ADDR_WIDTH(AW), .NBYTES(NB)) if1_b ();

    assign if0_a.valid = a_valid; assign if0_a.addr = a_addr; assign if0_a.wdata = a_wdata; assign if0_a.we = a_we;
    assign if0_b.valid = b_valid; assign if0_b.addr = b_addr; assign if0_b.wdata = b_wdata; assign if0_b.we = b_we;
    assign if1_a.valid = a_valid; assign if1_a.addr = a_addr; assign if1_a.wdata = a_wdata; assign if1_a.we = a_we;
    assign if1_b.valid = b_valid; assign if1_b.addr = b_addr; assign if1_b.wdata = b_wdata; assign if1_b.we = b_we;

    shared_ram_arb #(.ADDR_WIDTH(AW), .NBYTES(NB), .OUT_REG(0), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .resetn(resetn), .port_a(if0_a), .port_b(if0_b), .conflict_cnt(cnt0));
    shared_ram_arb #(.ADDR_WIDTH(AW), .NBYTES(NB), .OUT_REG(1), .CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .resetn(resetn), .port_a(if1_a), .port_b(if1_b), .conflict_cnt(cnt1));

    // Reference model state. Stream index k = dut*2 + port (port 0 = A).
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t         exp_q [4][$];
    logic [31:0] last_rd [4];
    logic [31:0] mem [64];
    bit          prio_b;
    int          nconf;
    int          cyc;
    int          n_vec;
    int          n_miss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_rdata(input int k);
        case (k)
            0:       return if0_a.rdata;
            1:       return if0_b.rdata;
            2:       return if1_a.rdata;
            default: return if1_b.rdata;
        endcase
    endfunction

    function automatic logic obs_rvalid(input int k);
        case (k)
            0:       return if0_a.rvalid;
            1:       return if0_b.rvalid;
            2:       return if1_a.rvalid;
            default: return if1_b.rvalid;
        endcase
    endfunction

    function automatic logic obs_ready(input int k);
        case (k)
            0:       return if0_a.ready;
            1:       return if0_b.ready;
            2:       return if1_a.ready;
            default: return if1_b.ready;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_rd[k] = 32'h0;
        end
        prio_b = 1'b0;
        nconf  = 0;
    endtask

    task automatic check_outputs();
        rd_t e;
        for (int k = 0; k < 4; k++) begin
            if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                e = exp_q[k].pop_front();
                check_eq($sformatf("rvalid%0d", k), 32'(obs_rvalid(k)), 32'h1);
                check_eq($sformatf("rdata%0d", k), obs_rdata(k), e.data);
                last_rd[k] = e.data;
            end else begin
                check_eq($sformatf("rvalid%0d", k), 32'(obs_rvalid(k)), 32'h0);
                check_eq($sformatf("rhold%0d", k), obs_rdata(k), last_rd[k]);
            end
        end
        check_eq("cnt16", 32'(cnt0), (nconf > 65535) ? 32'd65535 : 32'(nconf));
        check_eq("cnt3",  32'(cnt1), (nconf > 7) ? 32'd7 : 32'(nconf));
    endtask

    // One bus cycle on both ports, checked against the model.
    task automatic bus_cycle(input logic va, input logic [5:0] aa, input logic [31:0] wda, input logic [3:0] wea,
                             input logic vb, input logic [5:0] ba, input logic [31:0] wdb, input logic [3:0] web);
        bit  conf, ar, br;
        rd_t e;
        @(negedge clk);
        a_valid = va; a_addr = aa; a_wdata = wda; a_we = wea;
        b_valid = vb; b_addr = ba; b_wdata = wdb; b_we = web;
        #1;
        conf = va && vb && (aa == ba) && (wea != 4'h0 || web != 4'h0);
        ar = !conf || !prio_b;
        br = !conf || prio_b;
        for (int d = 0; d < 2; d++) begin
            check_eq("a_ready", 32'(obs_ready(2*d)), 32'(ar));
            check_eq("b_ready", 32'(obs_ready(2*d+1)), 32'(br));
        end
        if (va && ar && wea == 4'h0) begin
            e.data = mem[aa];
            e.due = cyc + 1; exp_q[0].push_back(e);
            e.due = cyc + 2; exp_q[2].push_back(e);
        end
        if (vb && br && web == 4'h0) begin
            e.data = mem[ba];
            e.due = cyc + 1; exp_q[1].push_back(e);
            e.due = cyc + 2; exp_q[3].push_back(e);
        end
        if (va && ar) mem[aa] = merge(mem[aa], wda, wea);
        if (vb && br) mem[ba] = merge(mem[ba], wdb, web);
        if (conf) begin
            prio_b = !prio_b;
            nconf++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 32'h0, 4'h0);
    endtask

    // Hold reset for n cycles while throwing random traffic at both ports.
    task automatic apply_reset(input int n);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        repeat (n) begin
            a_valid = 1'($urandom); a_addr = 6'($urandom); a_wdata = $urandom; a_we = 4'($urandom);
            b_valid = 1'($urandom); b_addr = 6'($urandom); b_wdata = $urandom; b_we = 4'($urandom);
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("rst_rvalid%0d", k), 32'(obs_rvalid(k)), 32'h0);
                check_eq($sformatf("rst_rdata%0d", k), obs_rdata(k), 32'h0);
            end
            check_eq("rst_cnt16", 32'(cnt0), 32'h0);
            check_eq("rst_cnt3",  32'(cnt1), 32'h0);
            @(negedge clk);
        end
        resetn = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_we = 4'h0; b_we = 4'h0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] va_v [4];
        logic [31:0] vb_v [4];
        n_vec = 0; n_miss = 0; cyc = 0;
        resetn = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_addr = 6'd0; b_addr = 6'd0;
        a_wdata = 32'h0; b_wdata = 32'h0; a_we = 4'h0; b_we = 4'h0;
        model_reset();

        // Reset with random traffic, then readies high.
        apply_reset(6);
        idle(1);

        // Initialise the whole memory through both ports at once.
        for (int i = 0; i < 32; i++)
            bus_cycle(1'b1, 6'(i), $urandom, 4'hF, 1'b1, 6'(63 - i), $urandom, 4'hF);

        // Byte enables and read latency.
        bus_cycle(1'b1, 6'd5, 32'h11223344, 4'hF, 1'b0, 6'd0, 32'h0, 4'h0);
        bus_cycle(1'b1, 6'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 6'd0, 32'h0, 4'h0);
        bus_cycle(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd5, 32'h0, 4'h0);
        idle(3);
        check_eq("byte_en_lat1", if0_b.rdata, 32'h11BB33DD);
        check_eq("byte_en_lat2", if1_b.rdata, 32'h11BB33DD);

        // Same-address write conflict: winners alternate A,B,A,B.
        apply_reset(2);
        for (int j = 0; j < 4; j++) begin
            va_v[j] = $urandom;
            vb_v[j] = $urandom;
            bus_cycle(1'b1, 6'd9, va_v[j], 4'hF, 1'b1, 6'd9, vb_v[j], 4'hF);
        end
        bus_cycle(1'b1, 6'd9, 32'h0, 4'h0, 1'b0, 6'd0, 32'h0, 4'h0);
        idle(3);
        check_eq("wconf_final", if0_a.rdata, vb_v[3]);
        check_eq("wconf_cnt", 32'(cnt0), 32'd4);

        // Same-address reads never conflict.
        apply_reset(2);
        repeat (4) bus_cycle(1'b1, 6'd3, 32'h0, 4'h0, 1'b1, 6'd3, 32'h0, 4'h0);
        idle(2);
        check_eq("rr_cnt", 32'(cnt0), 32'd0);

        // Counter saturation on the 3-bit instance.
        apply_reset(2);
        repeat (10) bus_cycle(1'b1, 6'd7, $urandom, 4'hF, 1'b1, 6'd7, $urandom, 4'hF);
        idle(3);
        check_eq("sat_cnt3", 32'(cnt1), 32'd7);
        check_eq("sat_cnt16", 32'(cnt0), 32'd10);

        // Reset with reads in flight, then A must win the first conflict.
        bus_cycle(1'b1, 6'd10, 32'h0, 4'h0, 1'b1, 6'd20, 32'h0, 4'h0);
        bus_cycle(1'b1, 6'd11, 32'h0, 4'h0, 1'b1, 6'd21, 32'h0, 4'h0);
        apply_reset(3);
        idle(3);
        bus_cycle(1'b1, 6'd12, $urandom, 4'hF, 1'b1, 6'd12, $urandom, 4'hF);
        idle(2);

        // Random traffic on a narrow address window to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            bus_cycle(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                      1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
